count_capture_fifo: RTL and testbench

//  Timestamp capture stage that sits directly downstream of the free-running 8-bit event counter.
//  On each rising edge of an external event line it snapshots the live counter value into a small FIFO.
//  The FIFO is drained by the consumer over a valid/ready handshake.

---
 rtl/count_capture_pkg.sv | 13 +
 rtl/count_capture_fifo_evt_sync_edge.sv | 34 +++
 rtl/count_capture_fifo.sv | 114 +++++++++++
 tb/tb_count_capture_fifo.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/count_capture_pkg.sv
// Shared constants and helpers for the count-capture timestamp FIFO.
package count_capture_pkg;

  localparam int                WIDTH_DEF = 8;
  localparam int                DROP_W    = 8;
  localparam logic [DROP_W-1:0] DROP_MAX  = 8'hFF;

  // Pointer index width for a power-of-two DEPTH (the wrap bit is added on top).
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/count_capture_fifo_evt_sync_edge.sv
// Synchronises the asynchronous event line and emits a one-cycle pulse on its
// rising edge. The pulse is combinational from the last sync flop and the prev flop.
module evt_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise_pulse
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  // Shift the raw line through the chain and remember the last synced level.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  // Chain and prev clear on reset, so a line held high across release gives one pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise_pulse = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/count_capture_fifo.sv
// Timestamp capture FIFO: snapshots count_in on each rising edge of evt_in,
// drains over valid/ready, and flags/counts events dropped while full.
module count_capture_fifo
  import count_capture_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEF,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         count_in,
  input  logic                     evt_in,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [DROP_W-1:0]        drop_cnt,
  input  logic                     clr_ovf
);

  localparam int PW = ptr_w(DEPTH);
  localparam int LW = PW + 1;

  localparam logic [PW:0]       PTR_ONE  = 1;
  localparam logic [LW-1:0]     LVL_ONE  = 1;
  localparam logic [DROP_W-1:0] DROP_ONE = 1;

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [WIDTH-1:0]  mem_d [DEPTH];
  logic [PW:0]       wr_ptr_q, wr_ptr_d;
  logic [PW:0]       rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic              ovf_q, ovf_d;
  logic [DROP_W-1:0] drop_q, drop_d;

  logic push, pop, full, wr_en, drop;

  evt_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_evt (
    .clk        (clk),
    .rst        (rst),
    .async_in   (evt_in),
    .rise_pulse (push)
  );

  // Full when indices match but the wrap bits differ.
  assign full      = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                     (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign out_valid = (level_q != '0);
  assign pop       = out_valid & out_ready;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign wr_en     = push & (~full | pop);
  assign drop      = push & full & ~pop;

  // Next-state for storage, pointers, level and the loss-reporting registers.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    drop_d   = drop_q;

    if (wr_en) begin
      mem_d[wr_ptr_q[PW-1:0]] = count_in;
      wr_ptr_d                = wr_ptr_q + PTR_ONE;
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;

    case ({wr_en, pop})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase

    // A drop in the clear cycle wins: the count restarts at one instead of zero.
    if (drop) begin
      ovf_d = 1'b1;
      if (clr_ovf)               drop_d = DROP_ONE;
      else if (drop_q != DROP_MAX) drop_d = drop_q + DROP_ONE;
    end else if (clr_ovf) begin
      ovf_d  = 1'b0;
      drop_d = '0;
    end
  end

  // Register everything; reset also clears storage so out_data reads zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      drop_q   <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      drop_q   <= drop_d;
    end
  end

  assign out_data = mem_q[rd_ptr_q[PW-1:0]];
  assign level    = level_q;
  assign overflow = ovf_q;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_count_capture_fifo.sv
// Scoreboard bench for count_capture_fifo: expected timestamps are queued as
// events are driven and compared as the consumer drains the FIFO.
module tb_count_capture_fifo;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] count_in;
  logic       evt_in;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] level;
  logic       overflow;
  logic [7:0] drop_cnt;
  logic       clr_ovf;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] exp_q[$];
  logic       exp_ovf;
  int         exp_drop;

  always #5 clk = ~clk;

  count_capture_fifo #(.WIDTH(8), .DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .count_in  (count_in),
    .evt_in    (evt_in),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt),
    .clr_ovf   (clr_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Check the status outputs against the model.
  task automatic chk_status(input string tag);
    chk({tag, ".level"}, 32'(level), 32'(exp_q.size()));
    chk({tag, ".valid"}, 32'(out_valid), 32'(exp_q.size() != 0));
    chk({tag, ".ovf"},   32'(overflow), 32'(exp_ovf));
    chk({tag, ".drop"},  32'(drop_cnt), 32'(exp_drop));
  endtask

  // Raise evt_in with count_in=v; the sync pulse lands two cycles later,
  // when out_ready/clr_ovf are applied for that single cycle.
  task automatic evt(input logic [7:0] v, input bit rdy, input bit clr, input bit full_chk);
    @(negedge clk); evt_in = 1'b1; count_in = v;
    @(negedge clk);
    @(negedge clk); out_ready = rdy; clr_ovf = clr;
    if (rdy && exp_q.size() > 0) begin
      chk("evt.pop_valid", 32'(out_valid), 32'd1);
      chk("evt.pop_data",  32'(out_data),  32'(exp_q.pop_front()));
    end
    @(negedge clk); out_ready = 1'b0; clr_ovf = 1'b0; evt_in = 1'b0;
    if (exp_q.size() < DEPTH) exp_q.push_back(v);
    else begin
      exp_ovf  = 1'b1;
      exp_drop = clr ? 1 : (exp_drop < 255 ? exp_drop + 1 : 255);
    end
    if (!rdy && clr && exp_q.size() < DEPTH) begin
      exp_ovf = 1'b0; exp_drop = 0;
    end
    if (full_chk) chk_status("evt");
  endtask

  task automatic pop_one();
    @(negedge clk);
    chk("pop.valid", 32'(out_valid), 32'd1);
    if (exp_q.size() > 0) chk("pop.data", 32'(out_data), 32'(exp_q.pop_front()));
    else chk("pop.model_nonempty", 32'd0, 32'd1);
    out_ready = 1'b1;
    @(negedge clk); out_ready = 1'b0;
    chk("pop.level", 32'(level), 32'(exp_q.size()));
  endtask

  task automatic drain();
    while (exp_q.size() > 0) pop_one();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; evt_in = 1'b0; count_in = 8'h00; out_ready = 1'b0; clr_ovf = 1'b0;
    exp_ovf = 1'b0; exp_drop = 0;

    // 1 Reset
    repeat (3) @(negedge clk);
    chk_status("reset");
    chk("reset.data", 32'(out_data), 32'h0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk_status("post_reset");

    // 2 Single capture with 1-cycle latency, then pop
    evt(8'h2A, 1'b0, 1'b0, 1'b1);
    chk("single.data", 32'(out_data), 32'h2A);
    pop_one();

    // Push+pop on empty: pop ignored, push taken
    evt(8'h55, 1'b1, 1'b0, 1'b1);
    pop_one();

    // 3 Fill and overflow
    evt(8'd10, 1'b0, 1'b0, 1'b0);
    evt(8'd20, 1'b0, 1'b0, 1'b0);
    evt(8'd30, 1'b0, 1'b0, 1'b0);
    evt(8'd40, 1'b0, 1'b0, 1'b1);
    evt(8'd50, 1'b0, 1'b0, 1'b1);
    chk("ovf.flag", 32'(overflow), 32'd1);
    chk("ovf.cnt",  32'(drop_cnt), 32'd1);
    drain();

    // 4 Full push+pop: accepted, drop_cnt unchanged
    evt(8'd1, 1'b0, 1'b0, 1'b0);
    evt(8'd2, 1'b0, 1'b0, 1'b0);
    evt(8'd3, 1'b0, 1'b0, 1'b0);
    evt(8'd4, 1'b0, 1'b0, 1'b1);
    evt(8'd99, 1'b1, 1'b0, 1'b1);
    chk("fullpp.cnt", 32'(drop_cnt), 32'd1);
    drain();

    // 5 Clear vs drop
    for (int i = 0; i < DEPTH; i++) evt(8'(8'h60 + i), 1'b0, 1'b0, 1'b0);
    evt(8'h70, 1'b0, 1'b0, 1'b0);
    evt(8'h71, 1'b0, 1'b0, 1'b1);
    chk("clr.pre_cnt", 32'(drop_cnt), 32'd3);
    evt(8'h72, 1'b0, 1'b1, 1'b1);
    chk("clr.drop_wins_cnt", 32'(drop_cnt), 32'd1);
    @(negedge clk); clr_ovf = 1'b1;
    @(negedge clk); clr_ovf = 1'b0; exp_ovf = 1'b0; exp_drop = 0;
    chk_status("clr_alone");
    for (int i = 0; i < 300; i++) evt(8'(i), 1'b0, 1'b0, 1'b0);
    chk_status("sat");
    chk("sat.cnt", 32'(drop_cnt), 32'd255);
    drain();

    // 6 Reset mid-stream, then a capture of 8'hFF
    evt(8'hA1, 1'b0, 1'b0, 1'b0);
    evt(8'hA2, 1'b0, 1'b0, 1'b0);
    evt(8'hA3, 1'b0, 1'b0, 1'b1);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    exp_q.delete(); exp_ovf = 1'b0; exp_drop = 0;
    chk_status("midrst");
    evt(8'hFF, 1'b0, 1'b0, 1'b1);
    pop_one();
    repeat (3) @(negedge clk);
    chk_status("final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
